cc_video_timing: RTL and testbench

- Horizontal/vertical video timing generator for the Crystal Castles core.
- Sits directly upstream of the 82S129 vertical-sync PROM: drives the PROM address and enable from its vertical counter.
- Consumes the 4-bit PROM output through an internal ls175-style latch, then produces sync, blank, IRQ and frame strobes for the video and CPU stages.

---
 rtl/cc_video_timing.sv | 126 ++++++++++++
 tb/tb_cc_video_timing.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_video_timing.sv
// Crystal Castles horizontal/vertical video timing generator driving the 82S129 vsync PROM.
// Define CC_VTIMING_NOPROM_EN to decode the vertical timing bits internally from vcount instead.
module cc_video_timing #(
  parameter int unsigned H_TOTAL  = 320,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned HS_START = 272,
  parameter int unsigned HS_END   = 296,
  parameter int unsigned H_LATCH  = 8
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       pix_ce,
  output logic [7:0] prom_addr,
  output logic       prom_en,
  input  logic [3:0] prom_data,
  input  logic       irq_ack,
  output logic [8:0] hcount,
  output logic [7:0] vcount,
  output logic       hblank,
  output logic       hsync_n,
  output logic       vblank,
  output logic       vsync_n,
  output logic       irq_n,
  output logic       frame_start
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] H_LAT  = 9'(H_LATCH);

  logic [8:0] hcount_q, hcount_d;
  logic [7:0] vcount_q, vcount_d;
  logic [3:0] latch_q, latch_d;
  logic       hblank_q, hblank_d;
  logic       hsync_n_q, hsync_n_d;
  logic       irq_n_q, irq_n_d;
  logic       frame_start_q, frame_start_d;
  logic [3:0] latch_src;
  logic       line_end;
  logic       latch_en;

`ifdef CC_VTIMING_NOPROM_EN
  // Bit order matches the PROM: {IRQCLK, VRESET, VBLANK, VSYNC}.
  logic unused_prom_data;
  assign unused_prom_data = ^prom_data;
  assign latch_src = {vcount_q[5], (vcount_q == 8'd255), (vcount_q < 8'd24), (vcount_q <= 8'd3)};
  assign prom_en   = 1'b0;
`else
  assign latch_src = prom_data;
  assign prom_en   = n_clr;
`endif

  // Next-state for counters, latch, sync/blank, IRQ and frame strobe.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    latch_d       = latch_q;
    hblank_d      = hblank_q;
    hsync_n_d     = hsync_n_q;
    irq_n_d       = irq_n_q;
    frame_start_d = 1'b0;
    line_end      = (hcount_q == H_LAST);
    latch_en      = 1'b0;
    if (pix_ce) begin
      hcount_d  = line_end ? 9'd0 : hcount_q + 9'd1;
      hblank_d  = (hcount_d >= H_ACT);
      hsync_n_d = !((hcount_d >= HS_S) && (hcount_d < HS_E));
      latch_en  = (hcount_d == H_LAT);
      if (line_end) begin
        vcount_d      = latch_q[2] ? 8'd0 : vcount_q + 8'd1;
        frame_start_d = (vcount_d == 8'd0);
      end else begin
        vcount_d      = vcount_q;
      end
      if (latch_en) begin
        latch_d = latch_src;
      end else begin
        latch_d = latch_q;
      end
    end else begin
      hcount_d = hcount_q;
    end
    // A rising IRQCLK on a latch update beats a coincident acknowledge.
    if (latch_en && !latch_q[3] && latch_src[3]) begin
      irq_n_d = 1'b0;
    end else if (irq_ack) begin
      irq_n_d = 1'b1;
    end else begin
      irq_n_d = irq_n_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      hcount_q      <= 9'd0;
      vcount_q      <= 8'd0;
      latch_q       <= 4'b0000;
      hblank_q      <= 1'b0;
      hsync_n_q     <= 1'b1;
      irq_n_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      latch_q       <= latch_d;
      hblank_q      <= hblank_d;
      hsync_n_q     <= hsync_n_d;
      irq_n_q       <= irq_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign prom_addr   = vcount_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hblank      = hblank_q;
  assign hsync_n     = hsync_n_q;
  assign vblank      = latch_q[1];
  assign vsync_n     = ~latch_q[0];
  assign irq_n       = irq_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_cc_video_timing.sv
// Directed self-checking bench for cc_video_timing with a registered PROM model.
module tb_cc_video_timing;

  logic       clk;
  logic       n_clr;
  logic       pix_ce;
  logic [7:0] prom_addr;
  logic       prom_en;
  logic [3:0] prom_data;
  logic       irq_ack;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       hblank;
  logic       hsync_n;
  logic       vblank;
  logic       vsync_n;
  logic       irq_n;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int vmax   = 0;
  int irq_lo = 4;
  int irq_hi = 7;
  int vres_line = 10;
  int vs_last = 0;

  cc_video_timing dut (
    .clk(clk), .n_clr(n_clr), .pix_ce(pix_ce), .prom_addr(prom_addr), .prom_en(prom_en),
    .prom_data(prom_data), .irq_ack(irq_ack), .hcount(hcount), .vcount(vcount),
    .hblank(hblank), .hsync_n(hsync_n), .vblank(vblank), .vsync_n(vsync_n),
    .irq_n(irq_n), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rom(input logic [7:0] a);
    rom[3] = (int'(a) >= irq_lo) && (int'(a) <= irq_hi);
    rom[2] = (int'(a) == vres_line);
    rom[1] = (int'(a) <= vs_last);
    rom[0] = (int'(a) <= vs_last);
  endfunction

  // PROM data follows the address one clock later
  always @(posedge clk) begin
`ifdef CC_VTIMING_NOPROM_EN
    prom_data <= 4'hF;
`else
    prom_data <= rom(prom_addr);
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel: pix_ce high for exactly one rising edge, then one idle edge
  task automatic step(input logic ack = 1'b0);
    @(negedge clk);
    pix_ce  = 1'b1;
    irq_ack = ack;
    @(negedge clk);
    pix_ce  = 1'b0;
    irq_ack = 1'b0;
    fs_cnt += int'(frame_start);
    if (int'(vcount) > vmax) vmax = int'(vcount);
  endtask

  task automatic ff(input int n);
    @(negedge clk);
    pix_ce = 1'b1;
    repeat (n) @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic run_to(input int v, input int h, input int budget);
    int n = 0;
    while (!(int'(vcount) == v && int'(hcount) == h) && n < budget) begin
      step();
      n++;
    end
    chk("reach_pos", {15'd0, vcount, hcount}, 32'((v << 9) | h));
  endtask

  initial begin
    n_clr   = 1'b0;
    pix_ce  = 1'b0;
    irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_hblank", hblank, 0);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vblank", vblank, 0);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_irq_n", irq_n, 1);
    chk("rst_frame_start", frame_start, 0);
    n_clr = 1'b1;
    #1;
`ifdef CC_VTIMING_NOPROM_EN
    chk("prom_en", prom_en, 0);
`else
    chk("prom_en", prom_en, 1);
`endif
    chk("prom_addr", prom_addr, 0);

    // Line 0: full walk of horizontal timing; line 0 latches VSYNC/VBLANK at hcount 8
    for (int i = 1; i <= 320; i++) begin
      int h;
      step();
      h = i % 320;
      chk("walk_hcount", hcount, h);
      chk("walk_hblank", hblank, (h >= 256));
      chk("walk_hsync_n", hsync_n, !((h >= 272) && (h < 296)));
      chk("walk_vsync_n", vsync_n, (i < 8));
      chk("walk_vblank", vblank, (i >= 8));
      chk("walk_vcount", vcount, (i == 320) ? 1 : 0);
    end
    chk("walk_no_frame_start", fs_cnt, 0);

`ifdef CC_VTIMING_NOPROM_EN
    for (int v = 1; v <= 24; v++) begin
      ff(8);
      chk("noprom_vsync_n", vsync_n, (v > 3));
      chk("noprom_vblank", vblank, (v < 24));
      ff(312);
    end
    ff(230 * 320 + 319);
    chk("noprom_last_v", vcount, 255);
    chk("noprom_last_h", hcount, 319);
    step();
    chk("noprom_wrap_v", vcount, 0);
    chk("noprom_frame_start", frame_start, 1);
`else
    // Line 1: PROM returns 0, so vsync/vblank release exactly at hcount 8
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("l1_vsync_n", vsync_n, (i == 8));
      chk("l1_vblank", vblank, (i < 8));
    end

    // IRQCLK high on lines 4..7
    run_to(4, 7, 2000);
    chk("irq_before_edge", irq_n, 1);
    step();
    chk("irq_set_h", hcount, 8);
    chk("irq_set", irq_n, 0);
    run_to(6, 100, 2000);
    chk("irq_held", irq_n, 0);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_acked", irq_n, 1);
    run_to(7, 300, 2000);
    chk("irq_no_reassert", irq_n, 1);

    // VRESET on line 10 ends the frame
    run_to(9, 319, 2000);
    step();
    chk("vres_pre_v", vcount, 10);
    run_to(10, 319, 2000);
    chk("vres_no_fs_yet", fs_cnt, 0);
    step();
    chk("vres_wrap_v", vcount, 0);
    chk("vres_wrap_h", hcount, 0);
    chk("vres_frame_start", frame_start, 1);
    step();
    chk("vres_fs_pulse_end", frame_start, 0);
    chk("vres_fs_count", fs_cnt, 1);
    chk("vres_vmax", vmax, 10);

    // Second frame: ack coincident with the set edge
    run_to(4, 7, 3000);
    chk("irq2_before", irq_n, 1);
    step(1'b1);
    chk("irq2_h", hcount, 8);
    chk("irq2_set_wins", irq_n, 0);

    // Mid-frame async reset with every output away from its reset value
    vs_last = 5;
    run_to(5, 280, 2000);
    chk("pre_rst_hblank", hblank, 1);
    chk("pre_rst_hsync_n", hsync_n, 0);
    chk("pre_rst_vsync_n", vsync_n, 0);
    chk("pre_rst_vblank", vblank, 1);
    chk("pre_rst_irq_n", irq_n, 0);
    @(negedge clk);
    n_clr = 1'b0;
    #1;
    chk("arst_hcount", hcount, 0);
    chk("arst_vcount", vcount, 0);
    chk("arst_hblank", hblank, 0);
    chk("arst_hsync_n", hsync_n, 1);
    chk("arst_vblank", vblank, 0);
    chk("arst_vsync_n", vsync_n, 1);
    chk("arst_irq_n", irq_n, 1);
    chk("arst_frame_start", frame_start, 0);
    repeat (3) step();
    chk("arst_hold_h", hcount, 0);
    chk("arst_hold_v", vcount, 0);
    vs_last = 0;
    @(negedge clk);
    n_clr = 1'b1;
    step();
    chk("rel_hcount", hcount, 1);
    chk("rel_vcount", vcount, 0);
    chk("rel_vsync_n", vsync_n, 1);
    chk("rel_vblank", vblank, 0);
    chk("rel_irq_n", irq_n, 1);
    run_to(0, 7, 100);
    step();
    chk("rel_latch_vsync_n", vsync_n, 0);
    chk("rel_fs_count", fs_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
